// File: rtl/i2c_pkg.sv
// Purpose: shared FSM state encoding and I2C bit-level constants for the register slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Purpose: synchronise an asynchronous pad, reject glitches shorter than FILTER_LEN clocks, flag edges.
// Latency: SYNC_STAGES + FILTER_LEN + 1 clocks from a pad edge to line_f / line_rise / line_fall.
// Backpressure: none; the pad is sampled every clock.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_in,
    output logic line_f,
    output logic line_rise,
    output logic line_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILTER_LEN-1:0]  hist_q, hist_d;
    logic                   line_q, line_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the synchroniser and history; accept a new level only when the whole history agrees.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
        hist_d = FILTER_LEN'({hist_q, sync_q[SYNC_STAGES-1]});
        line_d = line_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if ((&hist_q) && !line_q) begin
            line_d = 1'b1;
            rise_d = 1'b1;
        end else if (!(|hist_q) && line_q) begin
            line_d = 1'b0;
            fall_d = 1'b1;
        end
    end

    // State register; reset assumes an idle (pulled-up) bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= '1;
            line_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            line_q <= line_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign line_f    = line_q;
    assign line_rise = rise_q;
    assign line_fall = fall_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// Purpose: oversampled I2C slave exposing NUM_CH 8-bit registers (with write strobes) to the PWM bank.
// Latency: register/strobe update 1 CLK after the filtered SCL fall that opens the data ACK slot.
// Backpressure: none; no clock stretching, the master must respect the minimum SCL high/low times.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int         NUM_CH      = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SCL_IN,
    input  logic                SDA_IN,
    output logic                SDA_OE,
    output logic [NUM_CH*8-1:0] PWM_INTERFACE,
    output logic [NUM_CH-1:0]   WR_STROBE
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    i2c_state_t        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              byte_done_q, byte_done_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              rw_q, rw_d;
    logic              mack_q, mack_d;
    logic [PW-1:0]     ptr_q, ptr_d, ptr_inc;
    logic              sda_oe_q, sda_oe_d;
    logic [NUM_CH-1:0] wr_strobe_q, wr_strobe_d;
    logic [7:0]        regs_q [NUM_CH];
    logic [7:0]        regs_d [NUM_CH];
    logic [7:0]        rd_cur, rd_next;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(CLK), .rst(RST), .pad_in(SCL_IN),
        .line_f(scl_f), .line_rise(scl_rise), .line_fall(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(CLK), .rst(RST), .pad_in(SDA_IN),
        .line_f(sda_f), .line_rise(sda_rise), .line_fall(sda_fall)
    );

    // Both lines share the same filter latency, so scl_f is coherent with the SDA edge pulses.
    assign start_evt = sda_fall && scl_f;
    assign stop_evt  = sda_rise && scl_f;
    assign ptr_inc   = (ptr_q == PW'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
    assign rd_cur    = regs_q[ptr_q];
    assign rd_next   = regs_q[ptr_inc];

    // Protocol FSM: bus conditions first, then bit sampling on scl_rise and SDA updates on scl_fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = '0;
        regs_d      = regs_q;

        if (start_evt) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (stop_evt) begin
            state_d     = IDLE;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && !byte_done_q) begin
                        shreg_d   = {shreg_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        // Start of the ACK slot: act on the completed byte.
                        byte_done_d = 1'b0;
                        if (state_q == ADDR) begin
                            if (shreg_q[7:1] == SLAVE_ADDR) begin
                                state_d  = ADDR_ACK;
                                rw_d     = shreg_q[0];
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == PTR) begin
                            if ({1'b0, shreg_q} < 9'(NUM_CH)) begin
                                state_d  = PTR_ACK;
                                ptr_d    = PW'(shreg_q);
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            regs_d[ptr_q]      = shreg_q;
                            wr_strobe_d[ptr_q] = 1'b1;
                            ptr_d              = ptr_inc;
                            sda_oe_d           = 1'b1;
                            state_d            = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q == I2C_RW_READ) begin
                            state_d  = RDATA;
                            shreg_d  = rd_cur;
                            sda_oe_d = ~rd_cur[7];
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d   = WDATA;
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && !byte_done_q) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = RDATA_ACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_f;
                    end else if (scl_fall) begin
                        if (mack_q == I2C_ACK) begin
                            ptr_d     = ptr_inc;
                            shreg_d   = rd_next;
                            sda_oe_d  = ~rd_next[7];
                            bit_cnt_d = 3'd0;
                            state_d   = RDATA;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and register bank flops; reset aborts any transfer and releases SDA.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            shreg_q     <= 8'h00;
            rw_q        <= 1'b0;
            mack_q      <= I2C_NACK;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= '0;
            for (int k = 0; k < NUM_CH; k++) regs_q[k] <= RESET_VAL;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            regs_q      <= regs_d;
        end
    end

    assign SDA_OE    = sda_oe_q;
    assign WR_STROBE = wr_strobe_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pwm
        assign PWM_INTERFACE[8*k +: 8] = regs_q[k];
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Purpose: bit-banged I2C master driving i2c_reg_slave, checked against a byte-level register model.
// Latency: n/a (bench).
// Backpressure: n/a; the bench master never waits on the slave.
module tb_i2c_reg_slave;

    localparam int NUM_CH = 4;
    localparam int Q      = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                scl_m;
    logic                sda_m;
    logic                sda_line;
    logic                sda_oe;
    logic [NUM_CH*8-1:0] pwm;
    logic [NUM_CH-1:0]   wr_strobe;

    int n_checks = 0;
    int n_err    = 0;
    int oe_cnt   = 0;

    logic [7:0]        m_regs [NUM_CH];
    int                m_ptr;
    logic [7:0]        wbuf [8];
    logic [NUM_CH-1:0] strobe_log [$];

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low.
    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_slave #(
        .SLAVE_ADDR(7'h55), .NUM_CH(NUM_CH), .SYNC_STAGES(2), .FILTER_LEN(3), .RESET_VAL(8'h00)
    ) dut (
        .CLK(clk), .RST(rst), .SCL_IN(scl_m), .SDA_IN(sda_line),
        .SDA_OE(sda_oe), .PWM_INTERFACE(pwm), .WR_STROBE(wr_strobe)
    );

    // Log every cycle with a strobe active and count cycles with SDA driven.
    always @(negedge clk) begin
        if (!rst && wr_strobe != '0) strobe_log.push_back(wr_strobe);
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH*8-1:0] model_pwm();
        logic [NUM_CH*8-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[8*k +: 8] = m_regs[k];
        return v;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic seen);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        seen = sda_line;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(mack, s);
    endtask

    // Write transfer: address byte, pointer byte, n data bytes from wbuf.
    task automatic xfer_write(input logic [7:0] addr_b, input logic [7:0] p, input int n,
                              input bit do_stop, input bit glitch, input string tag);
        logic              ack;
        bit                matched, ptr_ok;
        logic [NUM_CH-1:0] exp_s [$];
        logic [NUM_CH-1:0] oh;
        strobe_log.delete();
        bus_start();
        wr_byte(addr_b, ack);
        matched = (addr_b[7:1] == 7'h55);
        ck({tag, "/addr_ack"}, 64'(ack), matched ? 64'(0) : 64'(1));
        wr_byte(p, ack);
        ptr_ok = matched && (int'(p) < NUM_CH);
        ck({tag, "/ptr_ack"}, 64'(ack), ptr_ok ? 64'(0) : 64'(1));
        if (ptr_ok) m_ptr = int'(p);
        if (glitch) begin
            wait_clk(4);
            scl_m = 1'b1;
            wait_clk(1);
            scl_m = 1'b0;
            wait_clk(4);
        end
        for (int i = 0; i < n; i++) begin
            wr_byte(wbuf[i], ack);
            ck({tag, "/data_ack"}, 64'(ack), ptr_ok ? 64'(0) : 64'(1));
            if (ptr_ok) begin
                m_regs[m_ptr] = wbuf[i];
                oh = '0;
                oh[m_ptr] = 1'b1;
                exp_s.push_back(oh);
                m_ptr = (m_ptr + 1) % NUM_CH;
            end
        end
        if (do_stop) bus_stop();
        ck({tag, "/strobe_cnt"}, 64'(strobe_log.size()), 64'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < strobe_log.size(); i++)
            ck({tag, "/strobe"}, 64'(strobe_log[i]), 64'(exp_s[i]));
        ck({tag, "/pwm"}, 64'(pwm), 64'(model_pwm()));
    endtask

    // Read transfer at the current pointer: ACK every byte but the last, NACK the last.
    task automatic xfer_read(input int n, input string tag);
        logic       ack;
        logic       mack;
        logic [7:0] d;
        strobe_log.delete();
        bus_start();
        wr_byte(8'hAB, ack);
        ck({tag, "/addr_ack"}, 64'(ack), 64'(0));
        for (int i = 0; i < n; i++) begin
            mack = (i == n - 1);
            rd_byte(mack, d);
            ck({tag, "/rd_data"}, 64'(d), 64'(m_regs[m_ptr]));
            if (!mack) m_ptr = (m_ptr + 1) % NUM_CH;
        end
        ck({tag, "/oe_after_nack"}, 64'(sda_oe), 64'(0));
        bus_stop();
        ck({tag, "/no_strobe"}, 64'(strobe_log.size()), 64'(0));
    endtask

    initial begin
        int         oe_before;
        logic       ack;
        logic       s;
        int         n;
        logic [7:0] p;

        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        for (int k = 0; k < NUM_CH; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(10);
        ck("reset/sda_oe", 64'(sda_oe), 64'(0));
        ck("reset/wr_strobe", 64'(wr_strobe), 64'(0));
        ck("reset/pwm", 64'(pwm), 64'(0));

        // 1. single write to channel 1
        wbuf[0] = 8'h3C;
        xfer_write(8'hAA, 8'h01, 1, 1'b1, 1'b0, "t1");
        ck("t1/ch1", 64'(pwm[15:8]), 64'(8'h3C));

        // 2. burst wrapping from channel 3 to channel 0, then confirm the pointer by reading
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        xfer_write(8'hAA, 8'h03, 2, 1'b1, 1'b0, "t2");
        ck("t2/ch3", 64'(pwm[31:24]), 64'(8'h11));
        ck("t2/ch0", 64'(pwm[7:0]), 64'(8'h22));
        xfer_read(1, "t2_ptr");

        // 3. fill ch1/ch2, set pointer, repeated START read of two bytes
        wbuf[0] = 8'h3C;
        wbuf[1] = 8'h5A;
        xfer_write(8'hAA, 8'h01, 2, 1'b1, 1'b0, "t3w");
        xfer_write(8'hAA, 8'h01, 0, 1'b0, 1'b0, "t3p");
        xfer_read(2, "t3r");

        // 4. foreign address: never driven, nothing written
        oe_before = oe_cnt;
        wbuf[0]   = 8'hFF;
        xfer_write(8'hA8, 8'h00, 1, 1'b1, 1'b0, "t4");
        ck("t4/oe_quiet", 64'(oe_cnt - oe_before), 64'(0));

        // 5. out-of-range pointer, then a write with a one-clock SCL glitch before the data
        wbuf[0] = 8'h99;
        xfer_write(8'hAA, 8'h07, 1, 1'b1, 1'b0, "t5bad");
        wbuf[0] = 8'h77;
        xfer_write(8'hAA, 8'h00, 1, 1'b1, 1'b1, "t5glitch");

        // 6. reset mid-byte during a write, then a normal transfer
        bus_start();
        wr_byte(8'hAA, ack);
        wr_byte(8'h00, ack);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
        rst = 1'b1;
        wait_clk(1);
        ck("t6/oe_in_reset", 64'(sda_oe), 64'(0));
        rst = 1'b0;
        wait_clk(1);
        for (int k = 0; k < NUM_CH; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        ck("t6/pwm_reset", 64'(pwm), 64'(0));
        bus_stop();
        wbuf[0] = 8'h42;
        xfer_write(8'hAA, 8'h02, 1, 1'b1, 1'b0, "t6after");

        // Randomised mix of writes (occasionally bad pointers) and pointer-set reads
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                p = 8'($urandom_range(0, NUM_CH + 1));
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                xfer_write(8'hAA, p, n, 1'b1, 1'b0, "rnd_w");
            end else begin
                p = 8'($urandom_range(0, NUM_CH - 1));
                xfer_write(8'hAA, p, 0, 1'b0, 1'b0, "rnd_p");
                xfer_read(n, "rnd_r");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
